// File: rtl/uart_line_echo.sv
// Line-assembly and echo stage between UART RX and TX: buffers printable bytes with
// backspace editing and, on CR, replays the line followed by CR LF over a valid/ready stream.
module uart_line_echo #(
  parameter int LINE_LENGTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] line_len,
  output logic       dropped,
  output logic       line_done
);

  localparam int         AW      = (LINE_LENGTH > 1) ? $clog2(LINE_LENGTH) : 1;
  localparam logic [7:0] MAX_LEN = 8'(LINE_LENGTH);
  localparam logic [7:0] CHR_CR  = 8'h0D;
  localparam logic [7:0] CHR_LF  = 8'h0A;
  localparam logic [7:0] CHR_BS  = 8'h08;
  localparam logic [7:0] CHR_DEL = 8'h7F;

  typedef enum logic [1:0] {
    COLLECT,
    EMIT,
    EMIT_CR,
    EMIT_LF
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] count, count_nxt;
  logic [7:0] index, index_nxt, index_inc;
  logic [7:0] tx_data_nxt;
  logic       tx_valid_nxt;
  logic       dropped_nxt;
  logic       line_done_nxt;
  logic       wr_en;
  logic       xfer;

  logic [7:0] line_buf [LINE_LENGTH];

  assign xfer      = tx_valid & tx_ready;
  assign index_inc = index + 8'd1;
  assign line_len  = count;

  always_comb begin
    state_nxt     = state;
    count_nxt     = count;
    index_nxt     = index;
    tx_data_nxt   = tx_data;
    tx_valid_nxt  = tx_valid;
    dropped_nxt   = 1'b0;
    line_done_nxt = 1'b0;
    wr_en         = 1'b0;

    case (state)
      COLLECT: begin
        if (rx_valid) begin
          case (rx_data)
            CHR_CR: begin
              tx_valid_nxt = 1'b1;
              if (count != 8'd0) begin
                state_nxt   = EMIT;
                index_nxt   = 8'd0;
                tx_data_nxt = line_buf[0];
              end else begin
                state_nxt   = EMIT_CR;
                tx_data_nxt = CHR_CR;
              end
            end
            CHR_LF: ;
            CHR_BS, CHR_DEL: begin
              if (count != 8'd0) count_nxt = count - 8'd1;
            end
            default: begin
              if (count < MAX_LEN) begin
                wr_en     = 1'b1;
                count_nxt = count + 8'd1;
              end else begin
                dropped_nxt = 1'b1;
              end
            end
          endcase
        end
      end

      EMIT: begin
        dropped_nxt = rx_valid;
        if (xfer) begin
          // count is at least 1 here, so count-1 cannot wrap
          if (index < count - 8'd1) begin
            index_nxt   = index_inc;
            tx_data_nxt = line_buf[index_inc[AW-1:0]];
          end else begin
            state_nxt   = EMIT_CR;
            tx_data_nxt = CHR_CR;
          end
        end
      end

      EMIT_CR: begin
        dropped_nxt = rx_valid;
        if (xfer) begin
          state_nxt   = EMIT_LF;
          tx_data_nxt = CHR_LF;
        end
      end

      EMIT_LF: begin
        dropped_nxt = rx_valid;
        if (xfer) begin
          state_nxt     = COLLECT;
          tx_valid_nxt  = 1'b0;
          tx_data_nxt   = 8'h00;
          count_nxt     = 8'd0;
          index_nxt     = 8'd0;
          line_done_nxt = 1'b1;
        end
      end

      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= COLLECT;
      count     <= 8'd0;
      index     <= 8'd0;
      tx_data   <= 8'h00;
      tx_valid  <= 1'b0;
      dropped   <= 1'b0;
      line_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      index     <= index_nxt;
      tx_data   <= tx_data_nxt;
      tx_valid  <= tx_valid_nxt;
      dropped   <= dropped_nxt;
      line_done <= line_done_nxt;
    end
  end

  // Buffer contents are don't-care after reset, so storage carries no reset
  always_ff @(posedge clk) begin
    if (wr_en && !rst) line_buf[count[AW-1:0]] <= rx_data;
  end

endmodule

// File: tb/tb_uart_line_echo.sv
// Scoreboard bench for uart_line_echo: a queue-based line model predicts the echoed
// byte stream, drop pulses and line lengths; a monitor checks every transfer.
module tb_uart_line_echo;

  localparam int LL = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] line_len;
  logic       dropped;
  logic       line_done;

  uart_line_echo #(.LINE_LENGTH(LL)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .line_len (line_len),
    .dropped  (dropped),
    .line_done(line_done)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] line_m[$];
  int         done_cnt = 0;
  int         drop_cnt = 0;
  int         exp_drop_total = 0;
  int         exp_lines = 0;
  int         ready_mode = 0;
  bit         emitting = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // 0: always ready, 1: random ready, 2: held off
  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = 1'($urandom_range(0, 1));
        default: tx_ready = 1'b0;
      endcase
    end
  end

  logic [7:0] mon_prev_data;
  logic [7:0] mon_exp;
  bit         mon_prev_hold = 0;
  bit         mon_prev_lf = 0;

  always @(negedge clk) begin
    if (rst) begin
      mon_prev_hold = 0;
      mon_prev_lf   = 0;
    end else begin
      if (mon_prev_hold) begin
        check("hold_valid", tx_valid, 1);
        check("hold_data", tx_data, mon_prev_data);
      end
      if (line_done === 1'b1 || mon_prev_lf) check("line_done", line_done, mon_prev_lf);
      if (line_done === 1'b1) done_cnt++;
      if (dropped === 1'b1) drop_cnt++;
      mon_prev_lf = 0;
      if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected: got 0x%02h expected no transfer at %0t", tx_data, $time);
        end else begin
          mon_exp = exp_q.pop_front();
          check("tx_byte", tx_data, mon_exp);
          mon_prev_lf = (mon_exp == 8'h0A);
        end
      end
      mon_prev_hold = (tx_valid === 1'b1 && tx_ready !== 1'b1);
      mon_prev_data = tx_data;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bit exp_drop = 0;
    bit is_cr = 0;
    if (emitting) exp_drop = 1;
    else if (b == 8'h0D) begin
      is_cr = 1;
      foreach (line_m[i]) exp_q.push_back(line_m[i]);
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
      exp_lines++;
      emitting = 1;
    end else if (b == 8'h0A) begin
    end else if (b == 8'h08 || b == 8'h7F) begin
      if (line_m.size() > 0) void'(line_m.pop_back());
    end else if (line_m.size() < LL) line_m.push_back(b);
    else exp_drop = 1;
    if (exp_drop) exp_drop_total++;
    @(posedge clk);
    #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    @(negedge clk);
    check("dropped", dropped, exp_drop);
    check("line_len", line_len, line_m.size());
    if (is_cr) check("cr_latency_valid", tx_valid, 1);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic wait_line_done(output int cycles);
    int target;
    target = exp_lines;
    cycles = 0;
    while (done_cnt < target && cycles < 500) begin
      @(negedge clk);
      #1;
      cycles++;
    end
    if (done_cnt < target) begin
      checks++;
      errors++;
      $display("FAIL line_timeout: got %0d lines expected %0d", done_cnt, target);
    end else begin
      check("line_len_after_lf", line_len, 0);
    end
    emitting = 0;
    line_m.delete();
  endtask

  initial begin
    int cyc;
    int n;
    int r;
    bit mid;
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_line_len", line_len, 0);
    check("rst_dropped", dropped, 0);
    check("rst_line_done", line_done, 0);
    // byte arriving together with reset must be ignored
    @(posedge clk);
    #1;
    rx_valid = 1'b1;
    rx_data  = 8'h41;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    rx_valid = 1'b0;
    @(negedge clk);
    check("rst_rx_ignored", line_len, 0);

    ready_mode = 0;
    send_str("ab");
    send_byte(8'h0D);
    wait_line_done(cyc);
    check("b2b_cycles_ab", cyc, 4);

    send_byte(8'h08);
    send_str("abc");
    send_byte(8'h08);
    send_str("d");
    send_byte(8'h0D);
    wait_line_done(cyc);

    send_str("123456");
    send_byte(8'h0D);
    wait_line_done(cyc);
    check("overflow_drops", drop_cnt, 2);

    ready_mode = 1;
    send_str("xyz");
    send_byte(8'h0D);
    wait_line_done(cyc);
    check("bp_all_transferred", exp_q.size(), 0);

    ready_mode = 0;
    send_byte(8'h0D);
    wait_line_done(cyc);
    check("bare_cr_cycles", cyc, 2);
    send_byte(8'h0A);
    repeat (3) @(negedge clk);
    check("lf_alone_idle", tx_valid, 0);

    send_str("ab");
    send_byte(8'h0D);
    send_byte(8'h71);
    wait_line_done(cyc);

    ready_mode = 2;
    send_str("abc");
    send_byte(8'h0D);
    repeat (3) @(negedge clk);
    check("stalled_valid", tx_valid, 1);
    @(posedge clk);
    #1;
    rst      = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h6B;
    exp_q.delete();
    line_m.delete();
    exp_lines--;
    emitting = 0;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    rx_valid = 1'b0;
    @(negedge clk);
    check("rst_emit_valid", tx_valid, 0);
    check("rst_emit_len", line_len, 0);
    ready_mode = 0;
    send_str("z");
    send_byte(8'h0D);
    wait_line_done(cyc);

    for (int k = 0; k < 40; k++) begin
      ready_mode = int'($urandom_range(0, 1));
      n = int'($urandom_range(0, 7));
      for (int j = 0; j < n; j++) begin
        r = int'($urandom_range(0, 9));
        if (r == 0) send_byte(($urandom_range(0, 1) != 0) ? 8'h08 : 8'h7F);
        else if (r == 1) send_byte(8'h0A);
        else send_byte(8'($urandom_range(32, 126)));
      end
      n = line_m.size();
      send_byte(8'h0D);
      mid = ($urandom_range(0, 3) == 0);
      if (mid) send_byte(8'($urandom_range(32, 126)));
      wait_line_done(cyc);
      if (ready_mode == 0 && !mid) check("rand_b2b_cycles", cyc, n + 2);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    repeat (5) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    check("final_drop_count", drop_cnt, exp_drop_total);
    check("final_line_count", done_cnt, exp_lines);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
